// File: rtl/barrel_unrotate_serial.sv
// Serial inverse of the barrel rotator: undoes a rotate one bit per clock.
// Valid/ready on both sides, one word in flight.
module barrel_unrotate_serial #(
   parameter int WIDTH = 8,
   parameter int MAG_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [MAG_W-1:0] shift_mag,
   input  logic             control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] out_q;
   logic [MAG_W-1:0] cnt;
   logic             dir;
   logic [WIDTH-1:0] rot;

   // One-bit rotate of the working word in the undo direction
   always_comb begin
      rot = dir ? {data_q[0], data_q[WIDTH-1:1]}
                : {data_q[WIDTH-2:0], data_q[WIDTH-1]};
   end

   // Control FSM with working word, count and separately held output word
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         data_q <= '0;
         out_q  <= '0;
         cnt    <= '0;
         dir    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data_q <= in_data;
                  cnt    <= shift_mag;
                  dir    <= ~control;
                  if (shift_mag != '0) begin
                     state <= SHIFT;
                  end else begin
                     out_q <= in_data;
                     state <= HOLD;
                  end
               end
            end
            SHIFT: begin
               data_q <= rot;
               cnt    <= cnt - MAG_W'(1);
               if (cnt == MAG_W'(1)) begin
                  out_q <= rot;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state == SHIFT);
   assign out_valid = (state == HOLD);
   assign out_data  = out_q;

endmodule

// File: tb/tb_barrel_unrotate_serial.sv
// Bench for barrel_unrotate_serial: timestamp model plus
// directed vectors and a full round-trip sweep.
module tb_barrel_unrotate_serial;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] shift_mag;
   logic       control;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       busy;

   int checks = 0;
   int failures = 0;

   barrel_unrotate_serial #(.WIDTH(8), .MAG_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .shift_mag (shift_mag),
      .control   (control),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rotl(input logic [7:0] x, input int m);
      logic [15:0] t;
      t = {x, x} << m;
      return t[15:8];
   endfunction

   function automatic logic [7:0] rotr(input logic [7:0] x, input int m);
      logic [15:0] t;
      t = {x, x} >> m;
      return t[7:0];
   endfunction

   function automatic logic [7:0] fwd(input logic [7:0] x, input int m,
                                      input logic c);
      return c ? rotr(x, m) : rotl(x, m);
   endfunction

   function automatic logic [7:0] unrot(input logic [7:0] x, input int m,
                                        input logic c);
      return c ? rotl(x, m) : rotr(x, m);
   endfunction

   task automatic chk_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_v(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: a word is in flight from accept until retire; it is visible
   // from cycle 'due' on (accept cycle + mag).
   int         cyc = 0;
   int         due = 0;
   bit         in_flight = 1'b0;
   bit         armed = 1'b0;
   logic [7:0] exp_word = 8'h00;
   logic [7:0] last_out = 8'h00;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         in_flight <= 1'b0;
         last_out  <= 8'h00;
         armed     <= 1'b1;
      end else if (!in_flight && in_valid) begin
         in_flight <= 1'b1;
         exp_word  <= unrot(in_data, int'(shift_mag), control);
         due       <= cyc + 1 + int'(shift_mag);
      end else if (in_flight && cyc >= due && out_ready) begin
         in_flight <= 1'b0;
         last_out  <= exp_word;
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk_b("in_ready", in_ready, !in_flight);
         chk_b("out_valid", out_valid, in_flight && cyc >= due);
         chk_b("busy", busy, in_flight && cyc < due);
         chk_v("out_data", int'(out_data),
               int'((in_flight && cyc >= due) ? exp_word : last_out));
      end
   end

   task automatic send(input logic [7:0] d, input logic [2:0] m,
                       input logic c);
      int k;
      in_data   = d;
      shift_mag = m;
      control   = c;
      in_valid  = 1'b1;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) chk_b("accept_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_data   = 8'($urandom);
      shift_mag = 3'($urandom);
      control   = 1'($urandom);
   endtask

   task automatic recv(input logic [7:0] exp, input bit rnd,
                       output int lat, output int bcnt);
      int n;
      lat  = 0;
      bcnt = 0;
      forever begin
         @(negedge clk);
         if (out_valid) break;
         if (busy) bcnt++;
         lat++;
         if (lat > 40) begin
            chk_b("valid_timeout", 1'b0, 1'b1);
            return;
         end
      end
      chk_v("restored", int'(out_data), int'(exp));
      n = 0;
      while (rnd && $urandom_range(0, 3) == 0 && n < 10) begin
         out_ready = 1'b0;
         @(negedge clk);
         chk_b("stall_valid", out_valid, 1'b1);
         n++;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int lat;
      int bc;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      shift_mag = 3'd0;
      control   = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_b("rst_in_ready", in_ready, 1'b1);
      chk_b("rst_out_valid", out_valid, 1'b0);
      chk_b("rst_busy", busy, 1'b0);
      chk_v("rst_out_data", int'(out_data), 0);

      // left, mag 2
      send(8'hF1, 3'd2, 1'b0);
      recv(8'h7C, 1'b0, lat, bc);
      chk_v("l2_latency", lat, 2);
      chk_v("l2_busy_cycles", bc, 2);
      @(negedge clk);
      chk_b("l2_in_ready_back", in_ready, 1'b1);

      // right, mags 1 and 3
      send(8'h32, 3'd1, 1'b1);
      recv(8'h64, 1'b0, lat, bc);
      chk_v("r1_latency", lat, 1);
      send(8'h26, 3'd3, 1'b1);
      recv(8'h31, 1'b0, lat, bc);
      chk_v("r3_latency", lat, 3);

      // zero magnitude
      send(8'h0E, 3'd0, 1'b0);
      recv(8'h0E, 1'b0, lat, bc);
      chk_v("z_latency", lat, 0);
      chk_v("z_busy_cycles", bc, 0);

      // backpressure with a competing input word
      out_ready = 1'b0;
      send(8'hA1, 3'd3, 1'b0);
      in_valid  = 1'b1;
      in_data   = 8'h55;
      shift_mag = 3'd0;
      control   = 1'b0;
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         lat++;
         @(negedge clk);
      end
      chk_v("bp_latency", lat, 3);
      for (int i = 0; i < 5; i++) begin
         chk_v("bp_hold_data", int'(out_data), 8'h34);
         chk_b("bp_hold_valid", out_valid, 1'b1);
         chk_b("bp_hold_in_ready", in_ready, 1'b0);
         if (i < 4) @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk_b("bp_in_ready_after", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk_b("bp_next_valid", out_valid, 1'b1);
      chk_v("bp_next_data", int'(out_data), 8'h55);
      @(posedge clk);
      #1;

      // reset in the middle of a rotation
      send(8'h80, 3'd7, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_b("mr_in_ready", in_ready, 1'b1);
      chk_b("mr_out_valid", out_valid, 1'b0);
      chk_b("mr_busy", busy, 1'b0);
      chk_v("mr_out_data", int'(out_data), 0);
      send(8'h02, 3'd1, 1'b0);
      recv(8'h01, 1'b0, lat, bc);
      chk_v("mr_next_latency", lat, 1);

      // full round trip with random output stalls
      for (int d = 0; d < 256; d++) begin
         for (int m = 0; m < 8; m++) begin
            for (int c = 0; c < 2; c++) begin
               send(fwd(8'(d), m, 1'(c)), 3'(m), 1'(c));
               recv(8'(d), 1'b1, lat, bc);
               chk_v("rt_latency", lat, m);
            end
         end
      end

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
